// File: rtl/screen_frame_scheduler_if.sv
// Character stream from the frame scheduler to the display driver.
// One character moves on each cycle where char_valid and char_ready are both high.
interface screen_frame_scheduler_if;
    logic       char_valid;
    logic [3:0] char_addr;
    logic [7:0] char_data;
    logic       char_ready;

    modport master (
        output char_valid,
        output char_addr,
        output char_data,
        input  char_ready
    );

    modport slave (
        input  char_valid,
        input  char_addr,
        input  char_data,
        output char_ready
    );
endinterface

// File: rtl/screen_frame_scheduler.sv
// Picks the screen frame for the current game state and streams it,
// one character at a time, to the 16-character display driver.
module screen_frame_scheduler #(
    parameter logic [3:0]  STAT_INITIAL   = 4'd0,
    parameter logic [3:0]  STAT_GAME      = 4'd1,
    parameter logic [3:0]  STAT_RESULT    = 4'd2,
    parameter logic [7:0]  BLANK_CHAR     = 8'h00,
    parameter logic [23:0] REFRESH_CYCLES = 24'd0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [3:0]                      state,
    input  logic [127:0]                    frame_initial,
    input  logic [127:0]                    frame_game,
    input  logic [127:0]                    frame_result,
    screen_frame_scheduler_if.master        chr,
    output logic                            frame_done,
    output logic                            busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_DONE
    } st_t;

    st_t          st_q;
    logic [127:0] sel_frame;
    logic [127:0] snap_q;
    logic [127:0] shadow_q;
    logic         dirty_q;
    logic [3:0]   idx_q;
    logic [3:0]   idx_d;
    logic [23:0]  rcnt_q;
    logic         valid_q;
    logic [3:0]   addr_q;
    logic [7:0]   data_q;
    logic         done_q;
    logic         busy_q;
    logic         refresh_hit;
    logic         start;

    // Char 0 sits in the top byte of a frame.
    function automatic logic [7:0] char_at(input logic [127:0] f,
                                           input logic [3:0]   i);
        logic [127:0] s;
        s = f << {i, 3'b000};
        return s[127:120];
    endfunction

    always_comb begin
        sel_frame = {16{BLANK_CHAR}};
        if (state == STAT_INITIAL)
            sel_frame = frame_initial;
        else if (state == STAT_GAME)
            sel_frame = frame_game;
        else if (state == STAT_RESULT)
            sel_frame = frame_result;
    end

    assign refresh_hit = (REFRESH_CYCLES != 24'd0) &&
                         (rcnt_q == REFRESH_CYCLES - 24'd1);
    assign start = (sel_frame != shadow_q) || dirty_q || refresh_hit;
    assign idx_d = idx_q + 4'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q     <= S_IDLE;
            snap_q   <= '0;
            shadow_q <= '0;
            dirty_q  <= 1'b1;
            idx_q    <= '0;
            rcnt_q   <= '0;
            valid_q  <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            unique case (st_q)
                S_IDLE: begin
                    if (start) begin
                        st_q   <= S_LOAD;
                        busy_q <= 1'b1;
                    end else if (REFRESH_CYCLES == 24'd0) begin
                        rcnt_q <= '0;
                    end else begin
                        rcnt_q <= rcnt_q + 24'd1;
                    end
                end
                S_LOAD: begin
                    snap_q  <= sel_frame;
                    idx_q   <= '0;
                    rcnt_q  <= '0;
                    dirty_q <= 1'b0;
                    valid_q <= 1'b1;
                    addr_q  <= '0;
                    data_q  <= char_at(sel_frame, 4'd0);
                    st_q    <= S_SEND;
                end
                S_SEND: begin
                    // Outputs only move once the current char is taken.
                    if (valid_q && chr.char_ready) begin
                        if (idx_q == 4'd15) begin
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            st_q    <= S_DONE;
                        end else begin
                            idx_q  <= idx_d;
                            addr_q <= idx_d;
                            data_q <= char_at(snap_q, idx_d);
                        end
                    end
                end
                S_DONE: begin
                    done_q   <= 1'b0;
                    shadow_q <= snap_q;
                    st_q     <= S_IDLE;
                end
                default: st_q <= S_IDLE;
            endcase
        end
    end

    assign chr.char_valid = valid_q;
    assign chr.char_addr  = addr_q;
    assign chr.char_data  = data_q;
    assign frame_done     = done_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_screen_frame_scheduler.sv
// Directed checks of the frame scheduler: full writes, change detection,
// backpressure, mid-transfer source switch, refresh and reset abort.
module tb_screen_frame_scheduler;

    localparam logic [127:0] F0 = 128'h0102030405060708090A0B0C0D0E0F10;
    localparam logic [127:0] F1 = 128'h0102030405AA0708090A0B0C0D0E0F10;
    localparam logic [127:0] F2 = 128'h5502030405AA0708090A0B0C0D0E0F10;
    localparam logic [127:0] F3 = 128'h5502030405AA0708090A0B0C0D0E0F77;
    localparam logic [127:0] FG = 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF;
    localparam logic [127:0] FR = 128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF;

    logic         clk;
    logic         rst_n;
    logic [3:0]   state;
    logic [127:0] frame_initial;
    logic [127:0] frame_game;
    logic [127:0] frame_result;
    logic         done_m;
    logic         busy_m;
    logic         done_r;
    logic         busy_r;

    int n_chk;
    int n_bad;

    screen_frame_scheduler_if chr_m ();
    screen_frame_scheduler_if chr_r ();

    screen_frame_scheduler dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .state         (state),
        .frame_initial (frame_initial),
        .frame_game    (frame_game),
        .frame_result  (frame_result),
        .chr           (chr_m),
        .frame_done    (done_m),
        .busy          (busy_m)
    );

    screen_frame_scheduler #(
        .REFRESH_CYCLES (24'd100)
    ) dut_r (
        .clk           (clk),
        .rst_n         (rst_n),
        .state         (state),
        .frame_initial (frame_initial),
        .frame_game    (frame_game),
        .frame_result  (frame_result),
        .chr           (chr_r),
        .frame_done    (done_r),
        .busy          (busy_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Receives one frame from the main DUT, optionally toggling ready
    // and switching state to GAME after sw_at accepted chars.
    task automatic run_frame(input bit tog, input int sw_at,
                             output logic [127:0] got, output int acc,
                             output int ord_bad, output int hold_bad,
                             output int lat, output int done_seen,
                             output logic done_busy);
        logic       pv;
        logic [3:0] pa;
        logic [7:0] pd;
        got = '0;
        acc = 0;
        ord_bad = 0;
        hold_bad = 0;
        lat = -1;
        done_seen = 0;
        done_busy = 1'b1;
        pv = 1'b0;
        pa = '0;
        pd = '0;
        for (int k = 0; k < 200 && done_seen == 0; k++) begin
            @(negedge clk);
            if (pv && !(chr_m.char_valid && chr_m.char_addr == pa &&
                        chr_m.char_data == pd))
                hold_bad++;
            chr_m.char_ready = tog ? (k % 4 == 0 || k % 4 == 3) : 1'b1;
            if (chr_m.char_valid && lat < 0)
                lat = k;
            if (done_m) begin
                done_seen = 1;
                done_busy = busy_m;
            end
            pv = chr_m.char_valid && !chr_m.char_ready;
            pa = chr_m.char_addr;
            pd = chr_m.char_data;
            if (chr_m.char_valid && chr_m.char_ready) begin
                if (acc > 15 || chr_m.char_addr != acc[3:0])
                    ord_bad++;
                if (acc < 16)
                    got[8*(15-acc) +: 8] = chr_m.char_data;
                acc++;
                if (acc == sw_at)
                    state = 4'd1;
            end
        end
        chr_m.char_ready = 1'b1;
    endtask

    // Waits for the next frame_done of the refresh DUT.
    task automatic wait_done_r(output int cyc, output int acc,
                               output logic [7:0] orv, output int mbusy);
        cyc = 0;
        acc = 0;
        orv = '0;
        mbusy = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            cyc++;
            if (busy_m)
                mbusy++;
            if (chr_r.char_valid && chr_r.char_ready) begin
                acc++;
                orv = orv | chr_r.char_data;
            end
            if (done_r)
                break;
        end
    endtask

    logic [127:0] got;
    int           acc;
    int           ord_bad;
    int           hold_bad;
    int           lat;
    int           dn;
    logic         dbusy;
    int           cyc;
    logic [7:0]   orv;
    int           mbusy;
    int           found;

    initial begin
        n_chk = 0;
        n_bad = 0;
        rst_n = 1'b0;
        state = 4'd0;
        frame_initial = F0;
        frame_game = FG;
        frame_result = FR;
        chr_m.char_ready = 1'b1;
        chr_r.char_ready = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst_valid", chr_m.char_valid, 1'b0);
        chk("rst_addr", chr_m.char_addr, 4'd0);
        chk("rst_data", chr_m.char_data, 8'd0);
        chk("rst_done", done_m, 1'b0);
        chk("rst_busy", busy_m, 1'b0);

        rst_n = 1'b1;
        run_frame(1'b0, -1, got, acc, ord_bad, hold_bad, lat, dn, dbusy);
        chk("t1_data", got, F0);
        chk("t1_acc", acc, 16);
        chk("t1_order", ord_bad, 0);
        chk("t1_done", dn, 1);
        chk("t1_lat", lat, 1);
        chk("t1_busy_done", dbusy, 1'b0);
        @(negedge clk);
        chk("t1_done_pulse", done_m, 1'b0);
        chk("t1_busy_idle", busy_m, 1'b0);
        chk("t1_valid_idle", chr_m.char_valid, 1'b0);
        repeat (5) @(negedge clk);
        chk("t1_stay_idle", busy_m, 1'b0);

        frame_initial = F1;
        run_frame(1'b0, -1, got, acc, ord_bad, hold_bad, lat, dn, dbusy);
        chk("t2_data", got, F1);
        chk("t2_acc", acc, 16);
        chk("t2_lat", lat, 1);
        chk("t2_done", dn, 1);
        @(negedge clk);

        frame_initial = F2;
        run_frame(1'b1, -1, got, acc, ord_bad, hold_bad, lat, dn, dbusy);
        chk("t3_data", got, F2);
        chk("t3_acc", acc, 16);
        chk("t3_order", ord_bad, 0);
        chk("t3_hold", hold_bad, 0);
        chk("t3_done", dn, 1);
        @(negedge clk);

        frame_initial = F3;
        run_frame(1'b0, 4, got, acc, ord_bad, hold_bad, lat, dn, dbusy);
        chk("t4_data_old", got, F3);
        chk("t4_acc", acc, 16);
        chk("t4_done", dn, 1);
        run_frame(1'b0, -1, got, acc, ord_bad, hold_bad, lat, dn, dbusy);
        chk("t4_data_game", got, FG);
        chk("t4_lat", lat, 2);
        chk("t4_done2", dn, 1);
        @(negedge clk);

        state = 4'd9;
        run_frame(1'b0, -1, got, acc, ord_bad, hold_bad, lat, dn, dbusy);
        chk("t5_blank", got, 128'h0);
        chk("t5_acc", acc, 16);
        wait_done_r(cyc, acc, orv, mbusy);
        chk("t5_r_seen1", done_r, 1'b1);
        wait_done_r(cyc, acc, orv, mbusy);
        chk("t5_r_seen2", done_r, 1'b1);
        wait_done_r(cyc, acc, orv, mbusy);
        chk("t5_r_period1", cyc, 118);
        chk("t5_r_acc1", acc, 16);
        chk("t5_r_blank1", orv, 8'h00);
        chk("t5_norefresh1", mbusy, 0);
        wait_done_r(cyc, acc, orv, mbusy);
        chk("t5_r_period2", cyc, 118);
        chk("t5_r_acc2", acc, 16);
        chk("t5_r_blank2", orv, 8'h00);
        chk("t5_norefresh2", mbusy, 0);

        state = 4'd0;
        found = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (chr_m.char_valid && chr_m.char_addr == 4'd7) begin
                found = 1;
                break;
            end
        end
        chk("t6_reach7", found, 1);
        chk("t6_data7", chr_m.char_data, 8'h08);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_valid", chr_m.char_valid, 1'b0);
        chk("t6_done", done_m, 1'b0);
        chk("t6_busy", busy_m, 1'b0);
        chk("t6_addr", chr_m.char_addr, 4'd0);
        rst_n = 1'b1;
        run_frame(1'b0, -1, got, acc, ord_bad, hold_bad, lat, dn, dbusy);
        chk("t6_data", got, F3);
        chk("t6_acc", acc, 16);
        chk("t6_lat", lat, 1);
        chk("t6_done2", dn, 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
